// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 19-bit CPU datapath.
// Walks each instruction through its multi-cycle state sequence and drives the
// datapath strobes. FETCH and OPERAND each last MEM_LAT+1 cycles to cover memory
// read latency. Every strobe is a decode of registered state gated by en; the only
// live input path into the strobes is the ZA/EQ flag test in BRANCH.
module instr_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       opcode,
    input  logic             za,
    input  logic             eq,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_a,
    output logic             load_b,
    output logic             load_c,
    output logic             wr_en_dm,
    output logic             sel_a,
    output logic             sel_b,
    output logic             alu_mode,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JEQ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_WB, S_STORE, S_BRANCH, S_HALT
    } state_t;

    // Raw strobe set before gating with en
    typedef struct packed {
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_a;
        logic load_b;
        logic load_c;
        logic wr_en_dm;
        logic sel_a;
        logic sel_b;
        logic alu_mode;
    } ctl_t;

    state_t     state, state_nxt;
    logic [2:0] wait_cnt, wait_nxt;
    logic [3:0] op_q;        // opcode captured in DECODE; WB and BRANCH need it later
    logic       illegal_q;   // set on leaving DECODE with an undefined opcode
    logic       ill_nxt;
    logic       retire;
    ctl_t       ctl;

    // Next-state, wait counter, retire and raw strobe decode
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ill_nxt   = 1'b0;
        retire    = 1'b0;
        ctl       = '0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
                wait_nxt  = '0;
            end
            S_FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    ctl.load_ir = 1'b1;
                    ctl.inc_pc  = 1'b1;
                    state_nxt   = S_DECODE;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_nxt = S_OPERAND;
                    OP_LDI:                 state_nxt = S_WB;
                    OP_ST:                  state_nxt = S_STORE;
                    OP_JMP, OP_JZ, OP_JEQ:  state_nxt = S_BRANCH;
                    OP_HLT:                 state_nxt = S_HALT;
                    default: begin
                        ill_nxt   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_OPERAND: begin
                ctl.sel_a = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    ctl.load_a = 1'b1;
                    ctl.load_b = 1'b1;
                    state_nxt  = S_EXEC;
                    wait_nxt   = '0;
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                end
            end
            S_EXEC: begin
                ctl.alu_mode = 1'b1;
                state_nxt    = S_WB;
            end
            S_WB: begin
                ctl.load_c   = 1'b1;
                ctl.sel_b    = (op_q == OP_LDI);
                ctl.alu_mode = (op_q != OP_LDI);
                retire       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_STORE: begin
                ctl.sel_a    = 1'b1;
                ctl.wr_en_dm = 1'b1;
                retire       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BRANCH: begin
                ctl.sel_a   = 1'b1;
                ctl.load_pc = (op_q == OP_JMP) || ((op_q == OP_JZ) && za) ||
                              ((op_q == OP_JEQ) && eq);
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, wait counter and retire counter advance only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired   <= '0;
        end else if (en) begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            illegal_q <= ill_nxt;
            if (state == S_DECODE) op_q <= opcode;
            if (retire) retired <= retired + 1'b1;
        end
    end

    // Strobes are gated by en so a frozen sequencer drives nothing
    assign load_ir  = ctl.load_ir  & en;
    assign inc_pc   = ctl.inc_pc   & en;
    assign load_pc  = ctl.load_pc  & en;
    assign load_a   = ctl.load_a   & en;
    assign load_b   = ctl.load_b   & en;
    assign load_c   = ctl.load_c   & en;
    assign wr_en_dm = ctl.wr_en_dm & en;
    assign sel_a    = ctl.sel_a    & en;
    assign sel_b    = ctl.sel_b    & en;
    assign alu_mode = ctl.alu_mode & en;
    assign illegal  = illegal_q    & en;
    assign halted   = (state == S_HALT);
    assign busy     = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table of single instructions
// (strobe counts, lengths, retire deltas) plus hand sequences for reset,
// HALT, async reset mid-EXEC and a MEM_LAT=3 / CNT_W=2 wrap run.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, za, eq;
    logic [3:0]  opcode;
    logic        load_ir, inc_pc, load_pc, load_a, load_b, load_c, wr_en_dm;
    logic        sel_a, sel_b, alu_mode, busy, halted, illegal;
    logic [15:0] retired;

    logic        rst2_n;
    logic [3:0]  opcode2;
    logic        load_ir2, inc_pc2, load_pc2, load_a2, load_b2, load_c2, wr_en_dm2;
    logic        sel_a2, sel_b2, alu_mode2, busy2, halted2, illegal2;
    logic [1:0]  retired2;

    instr_sequencer #(.MEM_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .za(za), .eq(eq),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_a(load_a),
        .load_b(load_b), .load_c(load_c), .wr_en_dm(wr_en_dm), .sel_a(sel_a),
        .sel_b(sel_b), .alu_mode(alu_mode), .busy(busy), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    instr_sequencer #(.MEM_LAT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en), .opcode(opcode2), .za(za), .eq(eq),
        .load_ir(load_ir2), .inc_pc(inc_pc2), .load_pc(load_pc2), .load_a(load_a2),
        .load_b(load_b2), .load_c(load_c2), .wr_en_dm(wr_en_dm2), .sel_a(sel_a2),
        .sel_b(sel_b2), .alu_mode(alu_mode2), .busy(busy2), .halted(halted2),
        .illegal(illegal2), .retired(retired2)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int excl_viol = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] strobes();
        return {load_ir, inc_pc, load_pc, load_a, load_b, load_c, wr_en_dm,
                sel_a, sel_b, alu_mode, illegal};
    endfunction

    function automatic logic [12:0] all_outs();
        return {strobes(), busy, halted};
    endfunction

    // One instruction: opcode/flags, optional en-off window, expected per-window counts.
    // len < 0 means the instruction length is not checked.
    typedef struct {
        string      name;
        logic [3:0] op;
        logic       za, eq;
        int         off_at, off_len;
        int         len, ld_ab, ld_c, alu, selb, sela, wr, ldpc, ret, ill;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic z,
                                input logic e, input int oa, input int ol, input int len,
                                input int ab, input int c, input int alu, input int sb,
                                input int sa, input int wr, input int pc, input int ret,
                                input int ill);
        vec_t v;
        v.name = n; v.op = op; v.za = z; v.eq = e; v.off_at = oa; v.off_len = ol;
        v.len = len; v.ld_ab = ab; v.ld_c = c; v.alu = alu; v.selb = sb; v.sela = sa;
        v.wr = wr; v.ldpc = pc; v.ret = ret; v.ill = ill;
        return v;
    endfunction

    // Step until load_ir is seen; inputs untouched
    task automatic wait_ir(input string nm);
        bit seen = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (load_ir) begin seen = 1; break; end
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
    endtask

    // Apply one vector starting at a load_ir sample; window ends at the next load_ir
    task automatic run_instr(input vec_t v);
        int n_a = 0, n_b = 0, n_c = 0, n_alu = 0, n_sb = 0, n_sa = 0;
        int n_wr = 0, n_pc = 0, n_ill = 0, len = 0, offv = 0;
        logic [15:0] r0, prev_ret, d;
        bit done = 0;
        opcode = v.op; za = v.za; eq = v.eq;
        r0 = retired; prev_ret = retired;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            en = !(v.off_len > 0 && c >= v.off_at && c < v.off_at + v.off_len);
            @(negedge clk);
            if ((load_pc && inc_pc) ||
                (wr_en_dm && (load_a || load_b || load_c || load_ir || load_pc)))
                excl_viol++;
            if (!en) begin
                if (strobes() != '0) offv++;
                if (c > v.off_at && retired != prev_ret) offv++;
            end
            prev_ret = retired;
            n_a += int'(load_a); n_b += int'(load_b); n_c += int'(load_c);
            n_alu += int'(alu_mode); n_sb += int'(sel_b); n_sa += int'(sel_a);
            n_wr += int'(wr_en_dm); n_pc += int'(load_pc); n_ill += int'(illegal);
            if (load_ir) begin done = 1; len = c; break; end
        end
        en = 1'b1;
        if (!done) chk({v.name, "_timeout"}, 0, 1);
        if (v.len >= 0) chk({v.name, "_len"}, len, v.len);
        chk({v.name, "_load_a"},   n_a,   v.ld_ab);
        chk({v.name, "_load_b"},   n_b,   v.ld_ab);
        chk({v.name, "_load_c"},   n_c,   v.ld_c);
        chk({v.name, "_alu_mode"}, n_alu, v.alu);
        chk({v.name, "_sel_b"},    n_sb,  v.selb);
        chk({v.name, "_sel_a"},    n_sa,  v.sela);
        chk({v.name, "_wr_en"},    n_wr,  v.wr);
        chk({v.name, "_load_pc"},  n_pc,  v.ldpc);
        chk({v.name, "_illegal"},  n_ill, v.ill);
        d = retired - r0;
        chk({v.name, "_retire"},   int'(d), v.ret);
        if (v.off_len > 0) chk({v.name, "_en_off_quiet"}, offv, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[17];
        int   ir_c, la_c, lb_c, lc_c, cyc, hv, start;
        logic [15:0] rh;
        int   exp_ret2[5] = '{1, 2, 3, 0, 1};
        logic [1:0] prev2;
        bit   found;

        //             name      op    za eq off     len ab c alu sb sa wr pc ret ill
        tbl[0]  = mk("alu1",    4'h1, 0, 0, 0, 0,  7, 1, 1, 2, 0, 2, 0, 0, 1, 0);
        tbl[1]  = mk("alu7",    4'h7, 1, 1, 0, 0,  7, 1, 1, 2, 0, 2, 0, 0, 1, 0);
        tbl[2]  = mk("ldi",     4'h8, 0, 0, 0, 0,  4, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        tbl[3]  = mk("store",   4'h9, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[4]  = mk("jmp",     4'hA, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        tbl[5]  = mk("jz_za0",  4'hB, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[6]  = mk("jz_za1",  4'hB, 1, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        tbl[7]  = mk("jeq_eq0", 4'hC, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[8]  = mk("jeq_eq1", 4'hC, 0, 1, 0, 0,  4, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        tbl[9]  = mk("jeq_za1", 4'hC, 1, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[10] = mk("jz_eq1",  4'hB, 0, 1, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[11] = mk("nop",     4'h0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk("ill_d",   4'hD, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk("ill_e",   4'hE, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk("alu_en0", 4'h1, 0, 0, 2, 5, 12, 1, 1, 2, 0, 2, 0, 0, 1, 0);
        tbl[15] = mk("st_en0",  4'h9, 0, 0, 2, 3,  7, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[16] = mk("ldi_en0", 4'h8, 0, 0, 3, 2,  6, 0, 1, 0, 1, 0, 0, 0, 1, 0);

        rst_n = 1'b0; rst2_n = 1'b0; en = 1'b1; za = 1'b0; eq = 1'b0;
        opcode = 4'h1; opcode2 = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'(all_outs()), 0);
        chk("reset_retired", int'(retired), 0);

        // First ALU instruction straight out of reset; cycle 1 is IDLE
        rst_n = 1'b1;
        ir_c = 0; la_c = 0; lb_c = 0; lc_c = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk); else #1;
            if (load_ir && ir_c == 0) ir_c = c;
            if (load_a  && la_c == 0) la_c = c;
            if (load_b  && lb_c == 0) lb_c = c;
            if (load_c  && lc_c == 0) lc_c = c;
        end
        chk("first_load_ir_cycle", ir_c, 3);
        chk("first_load_a_cycle",  la_c, 6);
        chk("first_load_b_cycle",  lb_c, 6);
        chk("first_load_c_cycle",  lc_c, 8);
        @(negedge clk);
        chk("first_retired", int'(retired), 1);
        wait_ir("second_fetch");

        foreach (tbl[i]) run_instr(tbl[i]);
        chk("exclusive_strobes", excl_viol, 0);

        // HALT: sticky, no strobes, no retire, BUSY low, whatever the inputs do
        opcode = 4'hF;
        rh = retired;
        @(negedge clk);
        chk("halt_decode_busy", int'(busy), 1);
        @(negedge clk);
        chk("halted", int'(halted), 1);
        chk("halt_busy", int'(busy), 0);
        hv = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            en = 1'($urandom_range(0, 1));
            opcode = 4'($urandom);
            za = 1'($urandom); eq = 1'($urandom);
            @(negedge clk);
            if (!halted || busy || strobes() != '0 || retired != rh) hv++;
        end
        en = 1'b1; za = 1'b0; eq = 1'b0;
        chk("halt_hold", hv, 0);

        // Async reset in the middle of EXEC
        rst_n = 1'b0;
        @(negedge clk);
        opcode = 4'h0;
        rst_n = 1'b1;
        wait_ir("rst_nop_fetch");
        wait_ir("rst_nop_done");
        chk("pre_abort_retired", int'(retired), 1);
        opcode = 4'h1;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (alu_mode && !load_c) begin found = 1; break; end
        end
        if (!found) chk("exec_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", int'(all_outs()), 0);
        chk("abort_retired", int'(retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 1; #1;
        while (!load_ir && cyc < 20) begin @(negedge clk); cyc++; end
        chk("restart_load_ir_cycle", cyc, 3);

        // MEM_LAT=3, CNT_W=2: five NOPs, 4-cycle fetches, counter wraps
        @(negedge clk);
        rst2_n = 1'b1;
        cyc = 1; #1;
        while (!load_ir2 && cyc < 30) begin @(negedge clk); cyc++; end
        chk("ml3_first_load_ir_cycle", cyc, 5);
        prev2 = retired2;
        for (int i = 0; i < 5; i++) begin
            start = 0; found = 0; cyc = 0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (start == 0 && retired2 != prev2) begin start = c; prev2 = retired2; end
                if (load_ir2) begin found = 1; cyc = c; break; end
            end
            if (!found) chk($sformatf("ml3_nop%0d_timeout", i), 0, 1);
            chk($sformatf("ml3_nop%0d_retired", i), int'(retired2), exp_ret2[i]);
            chk($sformatf("ml3_nop%0d_fetch_len", i), cyc - start + 1, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
